// File: rtl/jtlabrun_pkg.sv
// Shared definitions for the Labyrinth Runner / Fast Lane graphics ROM slot.
package jtlabrun_pkg;

  localparam int unsigned GFX_AW  = 17;
  localparam int unsigned GFX_DW  = 16;
  localparam int unsigned GFX_SDW = 22;

  // Word offset of the graphics region inside SDRAM for this game build.
  localparam logic [GFX_SDW-1:0] GFX_OFFSET = 22'h0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } romslot_state_e;

endpackage

// File: rtl/jtlabrun_gfx_romslot_if.sv
// Client (video) bus and SDRAM request bus used by the graphics ROM slot.
interface jtlabrun_gfx_client_if #(
  parameter int unsigned AW = 17,
  parameter int unsigned DW = 16
);
  logic [AW-1:0] addr;
  logic          cs;
  logic [DW-1:0] dout;
  logic          ok;

  modport master (output addr, cs, input  dout, ok);
  modport slave  (input  addr, cs, output dout, ok);
endinterface

interface jtlabrun_gfx_sdram_if #(
  parameter int unsigned SDW = 22,
  parameter int unsigned DW  = 16
);
  logic [SDW-1:0] addr;
  logic           req;
  logic           ack;
  logic           rdy;
  logic [DW-1:0]  din;

  modport master (output addr, req, input  ack, rdy, din);
  modport slave  (input  addr, req, output ack, rdy, din);
endinterface

// File: rtl/jtlabrun_romcache2.sv
// Two-entry word cache: tag/data/valid store, LRU bit, hit compare and fill port.
module jtlabrun_romcache2 #(
  parameter int unsigned AW = 17,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inval,
  input  logic [AW-1:0] lookup_addr,
  input  logic          touch,
  input  logic          fill_en,
  input  logic [AW-1:0] fill_tag,
  input  logic [DW-1:0] fill_data,
  output logic          hit_c,
  output logic [DW-1:0] rdata_c
);

  logic [1:0]         valid_q, valid_d;
  logic [1:0][AW-1:0] tag_q,   tag_d;
  logic [1:0][DW-1:0] data_q,  data_d;
  logic               lru_q,   lru_d;
  logic [1:0]         hit;

  // Tag compare; entry 0 wins when both entries match.
  always_comb begin
    hit[0]  = valid_q[0] & (tag_q[0] == lookup_addr);
    hit[1]  = valid_q[1] & (tag_q[1] == lookup_addr);
    hit_c   = |hit;
    rdata_c = hit[0] ? data_q[0] : (hit[1] ? data_q[1] : '0);
  end

  // Fill replaces the LRU entry and becomes most recent; a hit points LRU at the other entry.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    lru_d   = lru_q;
    if (touch) begin
      lru_d = hit[0];
    end
    if (fill_en) begin
      tag_d[lru_q]   = fill_tag;
      data_d[lru_q]  = fill_data;
      valid_d[lru_q] = 1'b1;
      lru_d          = ~lru_q;
    end
    if (inval) begin
      valid_d = '0;
    end
  end

  // Cache state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      lru_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      lru_q   <= lru_d;
    end
  end

endmodule

// File: rtl/jtlabrun_gfx_romslot.sv
// SDRAM-side responder for the graphics ROM port: 2-entry cache, misses become one-word reads.
module jtlabrun_gfx_romslot
  import jtlabrun_pkg::*;
#(
  parameter int unsigned    AW     = GFX_AW,
  parameter int unsigned    DW     = GFX_DW,
  parameter int unsigned    SDW    = GFX_SDW,
  parameter logic [SDW-1:0] OFFSET = SDW'(GFX_OFFSET)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 downloading,
  jtlabrun_gfx_client_if.slave gfx,
  jtlabrun_gfx_sdram_if.master sdram
);

  romslot_state_e state_q, state_d;
  logic [AW-1:0]  req_addr_q, req_addr_d;
  logic           sdram_req_q, sdram_req_d;
  logic [SDW-1:0] sdram_addr_q, sdram_addr_d;
  logic           discard_q, discard_d;
  logic           hit_c, ok_c, fill_c, fill_en_c;
  logic [DW-1:0]  rdata_c;

  jtlabrun_romcache2 #(
    .AW (AW),
    .DW (DW)
  ) u_cache (
    .clk         (clk),
    .rst         (rst),
    .inval       (downloading),
    .lookup_addr (gfx.addr),
    .touch       (ok_c),
    .fill_en     (fill_en_c),
    .fill_tag    (req_addr_q),
    .fill_data   (sdram.din),
    .hit_c       (hit_c),
    .rdata_c     (rdata_c)
  );

  // Client response is combinational so an address change drops ok in the same cycle.
  assign ok_c       = gfx.cs & hit_c & ~downloading;
  assign gfx.ok     = ok_c;
  assign gfx.dout   = rdata_c;
  assign sdram.req  = sdram_req_q;
  assign sdram.addr = sdram_addr_q;
  // Data of a fetch that overlapped a download is dropped.
  assign fill_en_c  = fill_c & ~discard_q & ~downloading;

  // Miss fetch sequencing and SDRAM handshake.
  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    sdram_req_d  = sdram_req_q;
    sdram_addr_d = sdram_addr_q;
    discard_d    = discard_q;
    fill_c       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        discard_d = 1'b0;
        if (gfx.cs & ~ok_c & ~downloading) begin
          req_addr_d   = gfx.addr;
          sdram_req_d  = 1'b1;
          sdram_addr_d = OFFSET + SDW'(gfx.addr);
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        if (downloading) discard_d = 1'b1;
        if (sdram.ack) begin
          sdram_req_d = 1'b0;
          if (sdram.rdy) begin
            fill_c  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (downloading) discard_d = 1'b1;
        if (sdram.rdy) begin
          fill_c  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        sdram_req_d = 1'b0;
      end
    endcase
  end

  // FSM and request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_addr_q   <= '0;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
      discard_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      sdram_req_q  <= sdram_req_d;
      sdram_addr_q <= sdram_addr_d;
      discard_q    <= discard_d;
    end
  end

endmodule

// File: tb/tb_jtlabrun_gfx_romslot.sv
// Self-checking bench for jtlabrun_gfx_romslot: vector table, directed sequences, random vs model.
module tb_jtlabrun_gfx_romslot;

  localparam logic [21:0] OFF = 22'h3FFF00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dl  = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  jtlabrun_gfx_client_if #(.AW(17), .DW(16)) gfx ();
  jtlabrun_gfx_sdram_if  #(.SDW(22), .DW(16)) sdram ();

  jtlabrun_gfx_romslot #(
    .AW(17), .DW(16), .SDW(22), .OFFSET(OFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (dl),
    .gfx         (gfx),
    .sdram       (sdram)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          cs, dl, ack, rdy;
    logic [16:0] addr;
    logic [15:0] din;
    bit          e_ok;
    logic [15:0] e_dout;
    bit          e_req;
    logic [21:0] e_sa;
  } vec_t;

  vec_t vq[$];

  function automatic logic [21:0] sa_of(input logic [16:0] a);
    return 22'((32'(OFF) + 32'(a)) & 32'h3F_FFFF);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs away from the rising edge, then let combinational outputs settle.
  task automatic drive(input bit r, input bit c, input bit d, input bit a, input bit y,
                       input logic [16:0] ad, input logic [15:0] dn);
    @(negedge clk);
    rst = r; gfx.cs = c; dl = d; sdram.ack = a; sdram.rdy = y; gfx.addr = ad; sdram.din = dn;
    #1;
  endtask

  task automatic chk_row(input string tag, input bit e_ok, input logic [15:0] e_dout,
                         input bit e_req, input logic [21:0] e_sa, input bit dchk);
    chk({tag, ".ok"},  32'(gfx.ok),     32'(e_ok));
    chk({tag, ".req"}, 32'(sdram.req),  32'(e_req));
    chk({tag, ".sa"},  32'(sdram.addr), 32'(e_sa));
    if (dchk || e_ok) chk({tag, ".dout"}, 32'(gfx.dout), 32'(e_dout));
  endtask

  // Reference model state for the random phase.
  logic [16:0] m_tag[2];
  logic [15:0] m_data[2];
  bit          m_valid[2];
  bit          m_lru, m_pend, m_acked, m_disc;
  logic [16:0] m_raddr;
  logic [21:0] m_sa;

  initial begin
    logic [16:0] pool[6];
    gfx.cs = 1'b0; gfx.addr = '0; sdram.ack = 1'b0; sdram.rdy = 1'b0; sdram.din = '0;

    // cs, dl, ack, rdy, addr, din | ok, dout, req, sdram_addr
    vq.push_back('{0,0,0,0,17'h00,16'h0000, 0,16'h0000,0,22'h0});
    vq.push_back('{1,0,0,0,17'h10,16'h0000, 0,16'h0000,0,22'h0});
    vq.push_back('{1,0,0,0,17'h10,16'h0000, 0,16'h0000,1,sa_of(17'h10)});
    vq.push_back('{1,0,0,0,17'h10,16'h0000, 0,16'h0000,1,sa_of(17'h10)});
    vq.push_back('{1,0,1,0,17'h10,16'h0000, 0,16'h0000,1,sa_of(17'h10)});
    vq.push_back('{1,0,0,0,17'h10,16'h0000, 0,16'h0000,0,sa_of(17'h10)});
    vq.push_back('{1,0,0,0,17'h10,16'h0000, 0,16'h0000,0,sa_of(17'h10)});
    vq.push_back('{1,0,0,1,17'h10,16'hBEEF, 0,16'h0000,0,sa_of(17'h10)});
    vq.push_back('{1,0,0,0,17'h10,16'h0000, 1,16'hBEEF,0,sa_of(17'h10)});
    vq.push_back('{1,0,0,0,17'h20,16'h0000, 0,16'h0000,0,sa_of(17'h10)});
    vq.push_back('{1,0,1,1,17'h20,16'hCAFE, 0,16'h0000,1,sa_of(17'h20)});
    vq.push_back('{1,0,0,0,17'h20,16'h0000, 1,16'hCAFE,0,sa_of(17'h20)});
    vq.push_back('{1,0,0,0,17'h10,16'h0000, 1,16'hBEEF,0,sa_of(17'h20)});
    vq.push_back('{1,0,0,0,17'h20,16'h0000, 1,16'hCAFE,0,sa_of(17'h20)});
    vq.push_back('{1,0,0,0,17'h10,16'h0000, 1,16'hBEEF,0,sa_of(17'h20)});
    vq.push_back('{1,0,0,0,17'h20,16'h0000, 1,16'hCAFE,0,sa_of(17'h20)});
    vq.push_back('{1,0,0,0,17'h30,16'h0000, 0,16'h0000,0,sa_of(17'h20)});
    vq.push_back('{1,0,1,0,17'h30,16'h0000, 0,16'h0000,1,sa_of(17'h30)});
    vq.push_back('{1,0,0,1,17'h30,16'h3333, 0,16'h0000,0,sa_of(17'h30)});
    vq.push_back('{1,0,0,0,17'h30,16'h0000, 1,16'h3333,0,sa_of(17'h30)});
    vq.push_back('{1,0,0,0,17'h20,16'h0000, 1,16'hCAFE,0,sa_of(17'h30)});
    vq.push_back('{1,0,0,0,17'h10,16'h0000, 0,16'h0000,0,sa_of(17'h30)});
    vq.push_back('{1,0,1,1,17'h10,16'h1010, 0,16'h0000,1,sa_of(17'h10)});
    vq.push_back('{1,0,0,0,17'h10,16'h0000, 1,16'h1010,0,sa_of(17'h10)});
    vq.push_back('{1,0,0,0,17'h20,16'h0000, 1,16'hCAFE,0,sa_of(17'h10)});
    vq.push_back('{1,0,0,0,17'h30,16'h0000, 0,16'h0000,0,sa_of(17'h10)});
    vq.push_back('{0,0,1,1,17'h30,16'h3030, 0,16'h0000,1,sa_of(17'h30)});
    vq.push_back('{0,0,0,0,17'h00,16'h0000, 0,16'h0000,0,sa_of(17'h30)});

    drive(1,0,0,0,0,17'h0,16'h0);
    drive(1,0,0,0,0,17'h0,16'h0);

    foreach (vq[i]) begin
      drive(0, vq[i].cs, vq[i].dl, vq[i].ack, vq[i].rdy, vq[i].addr, vq[i].din);
      chk_row($sformatf("row%0d", i), vq[i].e_ok, vq[i].e_dout, vq[i].e_req, vq[i].e_sa, 1'b1);
    end

    // Address moves from 'h40 to 'h50 while the 'h40 fetch is outstanding.
    drive(0,1,0,0,0,17'h40,16'h0);    chk_row("t4a", 0,16'h0,0,sa_of(17'h30),0);
    drive(0,1,0,1,0,17'h40,16'h0);    chk_row("t4b", 0,16'h0,1,sa_of(17'h40),0);
    drive(0,1,0,0,0,17'h50,16'h0);    chk_row("t4c", 0,16'h0,0,sa_of(17'h40),0);
    drive(0,1,0,0,1,17'h50,16'h4444); chk_row("t4d", 0,16'h0,0,sa_of(17'h40),0);
    drive(0,1,0,0,0,17'h50,16'h0);    chk_row("t4e", 0,16'h0,0,sa_of(17'h40),0);
    drive(0,1,0,1,0,17'h50,16'h0);    chk_row("t4f", 0,16'h0,1,sa_of(17'h50),0);
    drive(0,1,0,0,1,17'h50,16'h5555); chk_row("t4g", 0,16'h0,0,sa_of(17'h50),0);
    drive(0,1,0,0,0,17'h50,16'h0);    chk_row("t4h", 1,16'h5555,0,sa_of(17'h50),0);
    drive(0,1,0,0,0,17'h40,16'h0);    chk_row("t4i", 1,16'h4444,0,sa_of(17'h50),0);

    // Download begins while a fetch of 'h10 sits in WAIT.
    drive(0,1,0,0,0,17'h10,16'h0);    chk_row("t5a", 0,16'h0,0,sa_of(17'h50),0);
    drive(0,1,0,1,0,17'h10,16'h0);    chk_row("t5b", 0,16'h0,1,sa_of(17'h10),0);
    drive(0,1,1,0,0,17'h10,16'h0);    chk_row("t5c", 0,16'h0,0,sa_of(17'h10),0);
    drive(0,1,1,0,1,17'h40,16'hDDDD); chk_row("t5d", 0,16'h0,0,sa_of(17'h10),0);
    drive(0,1,0,0,0,17'h10,16'h0);    chk_row("t5e", 0,16'h0,0,sa_of(17'h10),1);
    drive(0,1,0,1,1,17'h10,16'h1111); chk_row("t5f", 0,16'h0,1,sa_of(17'h10),0);
    drive(0,1,0,0,0,17'h10,16'h0);    chk_row("t5g", 1,16'h1111,0,sa_of(17'h10),0);

    // Reset during REQ, then an orphan rdy.
    drive(0,1,0,0,0,17'h20,16'h0);    chk_row("t6a", 0,16'h0,0,sa_of(17'h10),0);
    drive(1,1,0,0,0,17'h20,16'h0);    chk_row("t6b", 0,16'h0,1,sa_of(17'h20),0);
    drive(0,0,0,0,0,17'h20,16'h0);    chk_row("t6c", 0,16'h0,0,22'h0,1);
    drive(0,0,0,0,1,17'h20,16'h9999); chk_row("t6d", 0,16'h0,0,22'h0,1);
    drive(0,1,0,0,0,17'h20,16'h0);    chk_row("t6e", 0,16'h0,0,22'h0,1);
    drive(0,1,0,1,1,17'h20,16'h0A0A); chk_row("t6f", 0,16'h0,1,sa_of(17'h20),0);
    drive(0,1,0,0,0,17'h20,16'h0);    chk_row("t6g", 1,16'h0A0A,0,sa_of(17'h20),0);

    // Random phase against the reference model.
    drive(1,0,0,0,0,17'h0,16'h0);
    drive(1,0,0,0,0,17'h0,16'h0);
    for (int k = 0; k < 2; k++) begin
      m_tag[k] = '0; m_data[k] = '0; m_valid[k] = 1'b0;
    end
    m_lru = 0; m_pend = 0; m_acked = 0; m_disc = 0; m_raddr = '0; m_sa = '0;
    pool[0] = 17'h10; pool[1] = 17'h20; pool[2] = 17'h30;
    pool[3] = 17'h40; pool[4] = 17'h10000; pool[5] = 17'h1FFFF;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit c, d, a, y, h0, h1, e_ok, fill;
      logic [16:0] ad;
      logic [15:0] dn, e_dout;
      c  = ($urandom_range(0, 9) < 8);
      d  = ($urandom_range(0, 49) == 0);
      ad = ($urandom_range(0, 9) == 0) ? 17'($urandom) : pool[$urandom_range(0, 5)];
      dn = 16'($urandom);
      if (m_pend && !m_acked) a = ($urandom_range(0, 9) < 4);
      else                    a = ($urandom_range(0, 49) == 0);
      if (m_pend && m_acked)  y = ($urandom_range(0, 19) < 7);
      else if (m_pend && a)   y = ($urandom_range(0, 4) == 0);
      else                    y = ($urandom_range(0, 49) == 0);
      drive(0, c, d, a, y, ad, dn);

      h0 = m_valid[0] && (m_tag[0] == ad);
      h1 = m_valid[1] && (m_tag[1] == ad);
      e_ok   = c && !d && (h0 || h1);
      e_dout = h0 ? m_data[0] : (h1 ? m_data[1] : 16'h0);
      chk_row($sformatf("rnd%0d", cyc), e_ok, e_dout, m_pend && !m_acked, m_sa, 1'b0);

      fill = 0;
      if (!m_pend) begin
        if (c && !e_ok && !d) begin
          m_pend = 1; m_acked = 0; m_disc = 0; m_raddr = ad; m_sa = sa_of(ad);
        end
      end else begin
        if (d) m_disc = 1;
        if ((m_acked || a) && y) begin
          fill   = !m_disc;
          m_pend = 0;
        end else if (a) begin
          m_acked = 1;
        end
      end
      if (fill) begin
        m_tag[m_lru] = m_raddr; m_data[m_lru] = dn; m_valid[m_lru] = 1; m_lru = !m_lru;
      end else if (e_ok) begin
        m_lru = h0;
      end
      if (d) begin
        m_valid[0] = 0; m_valid[1] = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
